// File: rtl/reg_bank_irq_pkg.sv
// reg_bank_irq_pkg: address-map helpers and defaults shared by the register bank
package reg_bank_irq_pkg;
  localparam logic [7:0] DEF_ID = 8'hA5;
  function automatic int roBase(input int numRw);
    return numRw;
  endfunction
  function automatic int statAddr(input int numRw, input int numRo);
    return numRw + numRo;
  endfunction
  function automatic int enAddr(input int numRw, input int numRo);
    return statAddr(numRw, numRo) + 1;
  endfunction
  function automatic int idAddr(input int numRw, input int numRo);
    return statAddr(numRw, numRo) + 2;
  endfunction
endpackage

// File: rtl/reg_bank_irq_irq_ctrl.sv
// irq_ctrl: sticky W1C interrupt status, enable mask and registered irq
module irq_ctrl #(
  parameter int NUM_EVT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evtIn,
  input  logic [NUM_EVT-1:0] clrMask,
  input  logic [NUM_EVT-1:0] enData,
  input  logic               statWe,
  input  logic               enWe,
  output logic [NUM_EVT-1:0] irqStat,
  output logic [NUM_EVT-1:0] irqEn,
  output logic               irq
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      irqStat <= '0;
      irqEn   <= '0;
      irq     <= 1'b0;
    end else begin
      // new events are ORed after the clear so a same-cycle set wins
      irqStat <= (statWe ? irqStat & ~clrMask : irqStat) | evtIn;
      if (enWe) irqEn <= enData;
      irq <= |(irqStat & irqEn);
    end
endmodule

// File: rtl/reg_bank_irq.sv
// reg_bank_irq: parametrised RW/RO register bank with interrupt status, enable and ID
module reg_bank_irq
  import reg_bank_irq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int NUM_RW  = 4,
  parameter int NUM_RO  = 4,
  parameter int NUM_EVT = 4,
  parameter logic [DATA_W-1:0] RW_RST   = '0,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(DEF_ID)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        dataIn,
  input  logic                     writeEn,
  output logic [DATA_W-1:0]        dataOut,
  output logic [NUM_RW*DATA_W-1:0] ctrl_out,
  input  logic [NUM_RO*DATA_W-1:0] status_in,
  input  logic [NUM_EVT-1:0]       evt_in,
  output logic                     irq
);
  localparam int RO_BASE   = roBase(NUM_RW);
  localparam int STAT_ADDR = statAddr(NUM_RW, NUM_RO);
  localparam int EN_ADDR   = enAddr(NUM_RW, NUM_RO);
  localparam int ID_ADDR   = idAddr(NUM_RW, NUM_RO);
  logic [DATA_W-1:0] rwReg [NUM_RW];
  logic [NUM_RO*DATA_W-1:0] statusQ;
  logic [NUM_EVT-1:0] irqStat, irqEn;
  logic [DATA_W-1:0] rdData;
  logic statWe, enWe;
  assign statWe = writeEn && addr == ADDR_W'(STAT_ADDR);
  assign enWe   = writeEn && addr == ADDR_W'(EN_ADDR);
  irq_ctrl #(.NUM_EVT(NUM_EVT)) u_irq (
    .clk     (clk),
    .rst     (rst),
    .evtIn   (evt_in),
    .clrMask (dataIn[NUM_EVT-1:0]),
    .enData  (dataIn[NUM_EVT-1:0]),
    .statWe  (statWe),
    .enWe    (enWe),
    .irqStat (irqStat),
    .irqEn   (irqEn),
    .irq     (irq)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_RW; i++) rwReg[i] <= RW_RST;
      statusQ <= '0;
      dataOut <= '0;
    end else begin
      for (int i = 0; i < NUM_RW; i++)
        if (writeEn && addr == ADDR_W'(i)) rwReg[i] <= dataIn;
      statusQ <= status_in;
      dataOut <= rdData;
    end
  // unmapped addresses fall through to zero
  always_comb begin
    rdData = '0;
    for (int i = 0; i < NUM_RW; i++)
      if (addr == ADDR_W'(i)) rdData = rwReg[i];
    for (int i = 0; i < NUM_RO; i++)
      if (addr == ADDR_W'(RO_BASE + i)) rdData = statusQ[i*DATA_W +: DATA_W];
    if (addr == ADDR_W'(STAT_ADDR)) rdData = DATA_W'(irqStat);
    if (addr == ADDR_W'(EN_ADDR)) rdData = DATA_W'(irqEn);
    if (addr == ADDR_W'(ID_ADDR)) rdData = ID_VALUE;
  end
  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
    assign ctrl_out[g*DATA_W +: DATA_W] = rwReg[g];
  end
endmodule

// File: tb/tb_reg_bank_irq.sv
// tb_reg_bank_irq: default and 16-bit instances checked against an address-map model
module tb_reg_bank_irq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0]  addr [2];
  logic [15:0] din  [2];
  logic        we   [2];
  logic [47:0] stIn [2];
  logic [15:0] evt  [2];
  logic [7:0]  dOut0;
  logic [15:0] dOut1;
  logic [31:0] ctrl0, ctrl1;
  logic        irq0, irq1;
  int checks = 0, fails = 0;
  logic [15:0] mRw [2][4];
  logic [15:0] mSamp [2][4];
  logic [15:0] mStat [2], mEn [2], mOut [2];
  logic        mIrq [2];
  reg_bank_irq dut0 (
    .clk(clk), .rst(rst), .addr(addr[0]), .dataIn(din[0][7:0]), .writeEn(we[0]),
    .dataOut(dOut0), .ctrl_out(ctrl0), .status_in(stIn[0][31:0]), .evt_in(evt[0][3:0]), .irq(irq0)
  );
  reg_bank_irq #(.DATA_W(16), .NUM_RW(2), .NUM_RO(3), .NUM_EVT(16)) dut1 (
    .clk(clk), .rst(rst), .addr(addr[1]), .dataIn(din[1]), .writeEn(we[1]),
    .dataOut(dOut1), .ctrl_out(ctrl1), .status_in(stIn[1]), .evt_in(evt[1]), .irq(irq1)
  );
  function automatic int nRw(input int i); return i ? 2 : 4; endfunction
  function automatic int nRo(input int i); return i ? 3 : 4; endfunction
  function automatic int dw(input int i); return i ? 16 : 8; endfunction
  function automatic logic [15:0] dMask(input int i); return i ? 16'hFFFF : 16'h00FF; endfunction
  function automatic logic [15:0] eMask(input int i); return i ? 16'hFFFF : 16'h000F; endfunction
  function automatic logic [15:0] dOut(input int i); return i ? dOut1 : {8'h00, dOut0}; endfunction
  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] modelRead(input int i, input int a);
    int sa = nRw(i) + nRo(i);
    if (a < nRw(i)) return mRw[i][a];
    if (a < sa) return mSamp[i][a - nRw(i)];
    if (a == sa) return mStat[i];
    if (a == sa + 1) return mEn[i];
    if (a == sa + 2) return 16'h00A5;
    return 16'h0000;
  endfunction
  function automatic logic [31:0] ctrlExp(input int i);
    logic [31:0] r = 0;
    for (int k = 0; k < nRw(i); k++) r |= 32'(mRw[i][k] & dMask(i)) << (k * dw(i));
    return r;
  endfunction
  task automatic modelReset(input int i);
    for (int k = 0; k < 4; k++) begin
      mRw[i][k] = 0;
      mSamp[i][k] = 0;
    end
    mStat[i] = 0;
    mEn[i] = 0;
    mOut[i] = 0;
    mIrq[i] = 0;
  endtask
  task automatic modelStep(input int i);
    int sa = nRw(i) + nRo(i);
    int a = int'(addr[i]);
    mOut[i] = modelRead(i, a);
    mIrq[i] = |(mStat[i] & mEn[i]);
    if (we[i]) begin
      if (a < nRw(i)) mRw[i][a] = din[i] & dMask(i);
      if (a == sa + 1) mEn[i] = din[i] & eMask(i);
      if (a == sa) mStat[i] = mStat[i] & ~din[i];
    end
    mStat[i] = (mStat[i] | evt[i]) & eMask(i);
    for (int k = 0; k < nRo(i); k++) mSamp[i][k] = 16'(stIn[i] >> (k * dw(i))) & dMask(i);
  endtask
  task automatic checkAll();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dataOut%0d", i), dOut(i), mOut[i]);
      check($sformatf("irq%0d", i), i ? irq1 : irq0, mIrq[i]);
      check($sformatf("ctrl%0d", i), i ? ctrl1 : ctrl0, ctrlExp(i));
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      if (rst) modelReset(i);
      else modelStep(i);
    @(negedge clk);
    checkAll();
  endtask
  task automatic wr(input int i, input int a, input logic [15:0] d);
    addr[i] = 8'(a);
    din[i] = d;
    we[i] = 1'b1;
    cyc();
    we[i] = 1'b0;
  endtask
  task automatic rd(input int i, input int a, input logic [15:0] exp);
    addr[i] = 8'(a);
    cyc();
    check($sformatf("read%0d@%0d", i, a), dOut(i), exp);
  endtask
  task automatic pulse(input int i, input logic [15:0] e);
    evt[i] = e;
    cyc();
    evt[i] = 0;
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      addr[i] = 0; din[i] = 0; we[i] = 0; stIn[i] = 0; evt[i] = 0;
      modelReset(i);
    end
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    check("reset_dout0", dOut0, 8'h00);
    check("reset_irq0", irq0, 1'b0);
    // RW walk on both geometries
    for (int k = 0; k < 4; k++) wr(0, k, 16'(8'h11 * (k + 1)));
    for (int k = 0; k < 2; k++) wr(1, k, 16'(16'h1111 * (k + 1)));
    for (int k = 0; k < 4; k++) rd(0, k, 16'(8'h11 * (k + 1)));
    for (int k = 0; k < 2; k++) rd(1, k, 16'(16'h1111 * (k + 1)));
    check("ctrl0_walk", ctrl0, 32'h44332211);
    check("ctrl1_walk", ctrl1, 32'h22221111);
    // RO / ID / unmapped
    stIn[0] = 48'h0000_DDCC_BBAA;
    stIn[1] = 48'h3333_2222_1111;
    wr(0, 4, 16'h00FF);
    wr(0, 10, 16'h00FF);
    wr(1, 2, 16'hFFFF);
    wr(1, 8, 16'hFFFF);
    rd(0, 4, 16'h00AA); rd(0, 5, 16'h00BB); rd(0, 6, 16'h00CC); rd(0, 7, 16'h00DD);
    rd(0, 10, 16'h00A5); rd(0, 11, 16'h0000);
    rd(1, 2, 16'h1111); rd(1, 3, 16'h2222); rd(1, 4, 16'h3333);
    rd(1, 7, 16'h00A5); rd(1, 8, 16'h0000);
    check("ctrl0_ro", ctrl0, 32'h44332211);
    // IRQ flow, default geometry
    wr(0, 9, 16'h0005);
    pulse(0, 16'h0002);
    cyc();
    check("irq0_masked", irq0, 1'b0);
    rd(0, 8, 16'h0002);
    pulse(0, 16'h0001);
    check("irq0_lat1", irq0, 1'b0);
    cyc();
    check("irq0_lat2", irq0, 1'b1);
    wr(0, 8, 16'h0001);
    cyc();
    check("irq0_cleared", irq0, 1'b0);
    rd(0, 8, 16'h0002);
    // set/clear collision
    wr(0, 8, 16'h0002);
    pulse(0, 16'h0004);
    cyc();
    check("irq0_bit2", irq0, 1'b1);
    evt[0] = 16'h0004;
    wr(0, 8, 16'h0004);
    evt[0] = 0;
    cyc();
    check("irq0_collide", irq0, 1'b1);
    rd(0, 8, 16'h0004);
    // IRQ flow, 16-bit geometry; disable keeps status, re-enable reasserts
    wr(1, 6, 16'h8001);
    pulse(1, 16'h4000);
    cyc();
    check("irq1_masked", irq1, 1'b0);
    pulse(1, 16'h8000);
    cyc();
    check("irq1_set", irq1, 1'b1);
    wr(1, 6, 16'h0000);
    cyc();
    check("irq1_disabled", irq1, 1'b0);
    rd(1, 5, 16'hC000);
    wr(1, 6, 16'h8000);
    cyc();
    check("irq1_reenabled", irq1, 1'b1);
    wr(1, 5, 16'h8000);
    cyc();
    check("irq1_cleared", irq1, 1'b0);
    rd(1, 5, 16'h4000);
    // randomized traffic
    repeat (600) begin
      for (int i = 0; i < 2; i++) begin
        addr[i] = 8'($urandom_range(0, nRw(i) + nRo(i) + 4));
        din[i] = 16'($urandom) & dMask(i);
        we[i] = $urandom_range(0, 2) == 0;
        evt[i] = $urandom_range(0, 4) == 0 ? 16'($urandom) & eMask(i) : 16'h0;
        if ($urandom_range(0, 7) == 0) stIn[i] = 48'({$urandom, $urandom});
      end
      cyc();
    end
    for (int i = 0; i < 2; i++) begin we[i] = 0; evt[i] = 0; end
    // asynchronous reset mid-run
    wr(0, 0, 16'h003C);
    wr(0, 9, 16'h0001);
    pulse(0, 16'h0001);
    rd(0, 0, 16'h003C);
    check("pre_rst_irq0", irq0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_ctrl0", ctrl0, 32'h0);
    check("async_dout0", dOut0, 8'h00);
    check("async_irq0", irq0, 1'b0);
    check("async_ctrl1", ctrl1, 32'h0);
    for (int i = 0; i < 2; i++) modelReset(i);
    evt[0] = 16'h000F;
    evt[1] = 16'hFFFF;
    cyc();
    evt[0] = 0;
    evt[1] = 0;
    rst = 1'b0;
    rd(0, 8, 16'h0000);
    rd(1, 5, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
